reg_scoreboard: RTL and testbench

Register-file scoreboard and issue controller for the decode stage. It tracks outstanding writes to each of the 32 architectural registers and stalls issue of any instruction whose source operands have pending writes. It also stalls when the destination's pending-write counter is saturated. It sits between the decode logic and the register file, and consumes the same write-back address/valid that drives the register file write port.

---
 rtl/reg_scoreboard_if.sv | 33 +++
 rtl/reg_scoreboard.sv | 121 ++++++++++++
 tb/tb_reg_scoreboard.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Issue/write-back bus between decode and the register scoreboard.
interface reg_scoreboard_if #(
  parameter int NREG = 32
) ();
  localparam int AW = $clog2(NREG);

  logic          issue_valid;
  logic [AW-1:0] issue_rs;
  logic [AW-1:0] issue_rt;
  logic          issue_use_rt;
  logic          issue_wr;
  logic [AW-1:0] issue_rd;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic          flush;
  logic          stall;
  logic          issue_fire;
  logic [NREG-1:0] busy_vec;
  logic [6:0]    pend_total;
  logic          wb_err;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_use_rt, issue_wr, issue_rd,
    output wb_valid, wb_addr, flush,
    input  stall, issue_fire, busy_vec, pend_total, wb_err
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_use_rt, issue_wr, issue_rd,
    input  wb_valid, wb_addr, flush,
    output stall, issue_fire, busy_vec, pend_total, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters, RAW and
// saturation stall, total outstanding count and sticky write-back error.

// Per-register pending-write counter with registered busy flag.
module reg_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;

  // Next count: flush wins, simultaneous inc/dec cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)             cnt_d = '0;
    else if (inc_i && !dec_i) cnt_d = cnt_q + CNT_W'(1);
    else if (dec_i && !inc_i) cnt_d = cnt_q - CNT_W'(1);
  end

  // Counter and busy state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= |cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = busy_q;
endmodule

module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic reset,
  reg_scoreboard_if.slave sb
);
  localparam int AW = $clog2(NREG);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [NREG-1:0][CNT_W-1:0] cnt_q;
  logic [NREG-1:0][CNT_W-1:0] eff;
  logic [NREG-1:0]            inc, dec, busy;
  logic                       stall, fire, inc_any, dec_any, wb_bad;
  logic [6:0]                 pend_q, pend_d;
  logic                       err_q;

  // Register 0 is hardwired zero: never counted, never busy.
  assign cnt_q[0] = '0;
  assign eff[0]   = '0;
  assign inc[0]   = 1'b0;
  assign dec[0]   = 1'b0;
  assign busy[0]  = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    assign dec[i] = sb.wb_valid && (sb.wb_addr == AW'(i)) && (cnt_q[i] != '0);
    assign inc[i] = fire && sb.issue_wr && (sb.issue_rd == AW'(i));
    // Same-cycle write-back releases its register for the hazard check.
    assign eff[i] = cnt_q[i] - CNT_W'(dec[i]);

    reg_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .flush_i (sb.flush),
      .inc_i   (inc[i]),
      .dec_i   (dec[i]),
      .cnt_o   (cnt_q[i]),
      .busy_o  (busy[i])
    );
  end

  // Hazard check; saturation deliberately uses cnt, not eff, to keep wb off the rd path.
  always_comb begin
    stall = sb.issue_valid &&
            ((eff[sb.issue_rs] != '0) ||
             (sb.issue_use_rt && (eff[sb.issue_rt] != '0)) ||
             (sb.issue_wr && (sb.issue_rd != '0) && (cnt_q[sb.issue_rd] == MAX)));
  end

  assign fire    = sb.issue_valid && !stall;
  assign inc_any = fire && sb.issue_wr && (sb.issue_rd != '0);
  assign dec_any = |dec;
  assign wb_bad  = sb.wb_valid && (cnt_q[sb.wb_addr] == '0);

  // Running total of outstanding writes.
  always_comb begin
    pend_d = pend_q;
    if (sb.flush)                 pend_d = '0;
    else if (inc_any && !dec_any) pend_d = pend_q + 7'd1;
    else if (dec_any && !inc_any) pend_d = pend_q - 7'd1;
  end

  // Total count and sticky error; only reset clears the error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (wb_bad) err_q <= 1'b1;
    end
  end

  assign sb.stall      = stall;
  assign sb.issue_fire = fire;
  assign sb.busy_vec   = busy;
  assign sb.pend_total = pend_q;
  assign sb.wb_err     = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.NREG(32)) sb ();

  reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    sb.issue_valid  = 1'b0;
    sb.issue_rs     = '0;
    sb.issue_rt     = '0;
    sb.issue_use_rt = 1'b0;
    sb.issue_wr     = 1'b0;
    sb.issue_rd     = '0;
    sb.wb_valid     = 1'b0;
    sb.wb_addr      = '0;
    sb.flush        = 1'b0;
  endtask

  task automatic iss(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                     input logic wr, input logic [4:0] rd);
    sb.issue_valid  = 1'b1;
    sb.issue_rs     = rs;
    sb.issue_rt     = rt;
    sb.issue_use_rt = use_rt;
    sb.issue_wr     = wr;
    sb.issue_rd     = rd;
  endtask

  task automatic wb(input logic [4:0] a);
    sb.wb_valid = 1'b1;
    sb.wb_addr  = a;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    // Reset: issues not recorded, fire follows valid, no stall.
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd5);
    #2;
    chk("rst_stall", 32'(sb.stall), 32'd0);
    chk("rst_fire", 32'(sb.issue_fire), 32'd1);
    step();
    chk("rst_busy", sb.busy_vec, 32'd0);
    chk("rst_pend", 32'(sb.pend_total), 32'd0);
    chk("rst_err", 32'(sb.wb_err), 32'd0);
    reset = 1'b1;
    idle();
    step();
    chk("idle_busy", sb.busy_vec, 32'd0);
    chk("idle_stall", 32'(sb.stall), 32'd0);

    // RAW stall and zero-cycle release.
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd5);
    #1 chk("raw_fire0", 32'(sb.issue_fire), 32'd1);
    step();
    chk("raw_busy5", sb.busy_vec, 32'h20);
    chk("raw_pend1", 32'(sb.pend_total), 32'd1);
    iss(5'd5, 5'd0, 1'b0, 1'b0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("raw_stall", 32'(sb.stall), 32'd1);
      chk("raw_nofire", 32'(sb.issue_fire), 32'd0);
      step();
    end
    wb(5'd5);
    #1 chk("raw_rel_stall", 32'(sb.stall), 32'd0);
    chk("raw_rel_fire", 32'(sb.issue_fire), 32'd1);
    step();
    idle();
    chk("raw_busy_clr", sb.busy_vec, 32'd0);
    chk("raw_pend0", 32'(sb.pend_total), 32'd0);

    // Saturation on rd=7.
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd7);
    step(); step(); step();
    chk("sat_pend3", 32'(sb.pend_total), 32'd3);
    chk("sat_busy7", sb.busy_vec, 32'h80);
    #1 chk("sat_stall", 32'(sb.stall), 32'd1);
    wb(5'd7);
    #1 chk("sat_stall_wb", 32'(sb.stall), 32'd1);
    step();
    chk("sat_pend2", 32'(sb.pend_total), 32'd2);
    sb.wb_valid = 1'b0;
    #1 chk("sat_refire", 32'(sb.issue_fire), 32'd1);
    step();
    idle();
    chk("sat_pend3b", 32'(sb.pend_total), 32'd3);
    wb(5'd7);
    step(); step(); step();
    idle();
    chk("sat_drain", 32'(sb.pend_total), 32'd0);
    chk("sat_busy0", sb.busy_vec, 32'd0);

    // Simultaneous issue and write-back to the same register.
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd9);
    step();
    chk("sim_pend1", 32'(sb.pend_total), 32'd1);
    wb(5'd9);
    #1 chk("sim_fire", 32'(sb.issue_fire), 32'd1);
    step();
    idle();
    chk("sim_pend", 32'(sb.pend_total), 32'd1);
    chk("sim_busy9", sb.busy_vec, 32'h200);
    // rt only counts when use_rt is set.
    iss(5'd0, 5'd9, 1'b0, 1'b0, 5'd0);
    #1 chk("rt_unused", 32'(sb.stall), 32'd0);
    sb.issue_use_rt = 1'b1;
    #1 chk("rt_used", 32'(sb.stall), 32'd1);
    // All-zero operands never stall and rd=0 is not counted.
    iss(5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
    #1 chk("r0_stall", 32'(sb.stall), 32'd0);
    chk("r0_fire", 32'(sb.issue_fire), 32'd1);
    step();
    idle();
    chk("r0_pend", 32'(sb.pend_total), 32'd1);
    wb(5'd9);
    step();
    idle();
    chk("sim_drain", 32'(sb.pend_total), 32'd0);
    chk("err_clean", 32'(sb.wb_err), 32'd0);

    // Spurious write-back, then flush.
    wb(5'd12);
    step();
    idle();
    chk("err_set", 32'(sb.wb_err), 32'd1);
    chk("err_pend", 32'(sb.pend_total), 32'd0);
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd3);
    step();
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd4);
    step();
    chk("fl_busy_pre", sb.busy_vec, 32'h18);
    chk("fl_pend_pre", 32'(sb.pend_total), 32'd2);
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd6);
    wb(5'd3);
    sb.flush = 1'b1;
    step();
    idle();
    chk("fl_busy", sb.busy_vec, 32'd0);
    chk("fl_pend", 32'(sb.pend_total), 32'd0);
    chk("fl_err", 32'(sb.wb_err), 32'd1);

    // Async reset mid-run.
    for (int r = 1; r <= 4; r++) begin
      iss(5'd0, 5'd0, 1'b0, 1'b1, 5'(r));
      step();
    end
    idle();
    chk("ar_pend4", 32'(sb.pend_total), 32'd4);
    chk("ar_busy", sb.busy_vec, 32'h1E);
    #1 reset = 1'b0;
    iss(5'd1, 5'd2, 1'b1, 1'b0, 5'd0);
    #1;
    chk("ar_busy0", sb.busy_vec, 32'd0);
    chk("ar_pend0", 32'(sb.pend_total), 32'd0);
    chk("ar_err0", 32'(sb.wb_err), 32'd0);
    chk("ar_stall", 32'(sb.stall), 32'd0);
    chk("ar_fire", 32'(sb.issue_fire), 32'd1);
    step();
    reset = 1'b1;
    idle();
    wb(5'd1);
    step();
    idle();
    chk("ar_stale_wb", 32'(sb.wb_err), 32'd1);
    chk("ar_stale_pend", 32'(sb.pend_total), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
